// File: rtl/link_pkg.sv
// Shared width helpers for the link credit arbiter slice.
package link_pkg;

  // Width needed to hold a credit count in the range 0..credits.
  function automatic int credit_w(input int credits);
    return $clog2(credits + 32'sd1);
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/link_credit_arbiter_rr.sv
// Round-robin arbiter: combinational wrap-around search from a pointer
// register that moves just past the winner whenever a grant is consumed.
module rr_arbiter
  import link_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic                           advance_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [idx_w(NUM_REQ)-1:0]      idx_o,
  output logic                           any_o
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      ptr_d;
  logic [IW:0]        cand_s;
  logic [IW-1:0]      idx_s;
  logic               found_s;
  logic [NUM_REQ-1:0] grant_s;

  // Scan requesters starting at the pointer, wrapping; first valid wins.
  always_comb begin
    idx_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        idx_s   = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant_s = NUM_REQ'(1) << idx_s;
    end else begin
      grant_s = '0;
    end
  end

  // Pointer moves to the slot after the winner only when a grant is taken.
  always_comb begin
    if (advance_i && found_s) begin
      if (idx_s == IW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_s + IW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o = grant_s;
  assign idx_o   = idx_s;
  assign any_o   = found_s;

endmodule

// File: rtl/link_credit_arbiter.sv
// Transmit-side link arbiter: round-robin selection among requesters into a
// single registered output beat, gated by credits from the far-end receiver.
module link_credit_arbiter
  import link_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 32,
  parameter int CREDITS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_p_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           link_valid_o,
  output logic [PAYLOAD_W-1:0]           link_p_o,
  input  logic                           link_ready_i,
  input  logic                           credit_return_i,
  output logic [credit_w(CREDITS)-1:0]   credit_count_o,
  output logic [idx_w(NUM_REQ)-1:0]      grant_idx_o,
  output logic                           credit_overflow_o
);

  localparam int             CW        = credit_w(CREDITS);
  localparam int             IW        = idx_w(NUM_REQ);
  localparam logic [CW-1:0]  CREDITS_C = CW'(CREDITS);

  logic                 link_valid_q, link_valid_d;
  logic [PAYLOAD_W-1:0] link_p_q, link_p_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic                 ovf_q, ovf_d;

  logic                 load_en_s;
  logic                 do_load_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic [IW-1:0]        win_idx_s;
  logic                 any_s;
  logic [PAYLOAD_W-1:0] win_p_s;

  // The output slot can take a beat when it is empty or draining, and only
  // while the receiver still has buffer space for it.
  assign load_en_s = (!link_valid_q || link_ready_i) && (credit_q != '0);
  assign do_load_s = load_en_s && any_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid_i),
    .advance_i (load_en_s),
    .grant_o   (grant_s),
    .idx_o     (win_idx_s),
    .any_o     (any_s)
  );

  // Ready goes only to the current winner, and only when a load can happen.
  always_comb begin
    if (load_en_s) begin
      req_ready_o = grant_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // One-hot OR mux of the winning payload.
  always_comb begin
    win_p_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        win_p_s = req_p_i[i*PAYLOAD_W +: PAYLOAD_W];
      end else begin
        win_p_s = win_p_s;
      end
    end
  end

  // Output beat: load a new beat, clear on acceptance, otherwise hold.
  always_comb begin
    link_p_d = link_p_q;
    grant_d  = grant_q;
    if (do_load_s) begin
      link_valid_d = 1'b1;
      link_p_d     = win_p_s;
      grant_d      = win_idx_s;
    end else if (link_ready_i && link_valid_q) begin
      link_valid_d = 1'b0;
    end else begin
      link_valid_d = link_valid_q;
    end
  end

  // Credit counter: spend at load, refund on return, saturate and flag a
  // return that arrives with the counter already full.
  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    case ({do_load_s, credit_return_i})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CREDITS_C) begin
          ovf_d = 1'b1;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // State registers; reset drops any held beat and restores full credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_valid_q <= 1'b0;
      link_p_q     <= '0;
      grant_q      <= '0;
      credit_q     <= CREDITS_C;
      ovf_q        <= 1'b0;
    end else begin
      link_valid_q <= link_valid_d;
      link_p_q     <= link_p_d;
      grant_q      <= grant_d;
      credit_q     <= credit_d;
      ovf_q        <= ovf_d;
    end
  end

  assign link_valid_o      = link_valid_q;
  assign link_p_o          = link_p_q;
  assign grant_idx_o       = grant_q;
  assign credit_count_o    = credit_q;
  assign credit_overflow_o = ovf_q;

endmodule

// File: tb/tb_link_credit_arbiter.sv
// Self-checking bench for link_credit_arbiter: directed vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_link_credit_arbiter;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int CR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_p;
  logic [N-1:0]    req_ready;
  logic            link_valid;
  logic [PW-1:0]   link_p;
  logic            link_ready;
  logic            credit_return;
  logic [2:0]      credit_count;
  logic [1:0]      grant_idx;
  logic            credit_overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers, rules applied directly).
  bit            m_valid;
  logic [PW-1:0] m_p;
  int            m_grant, m_count, m_ptr;
  bit            m_ovf;
  logic [N-1:0]  obs_ready;

  typedef struct {
    logic [3:0] rv;
    logic       lr;
    logic       cr;
    logic [3:0] exp_ready;
    logic       exp_valid;
    int         exp_grant;
    int         exp_count;
  } vec_t;

  vec_t vecs[6];
  int   exp_g[4];

  always #5 clk = ~clk;

  link_credit_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .CREDITS(CR)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_p_i           (req_p),
    .req_ready_o       (req_ready),
    .link_valid_o      (link_valid),
    .link_p_o          (link_p),
    .link_ready_i      (link_ready),
    .credit_return_i   (credit_return),
    .credit_count_o    (credit_count),
    .grant_idx_o       (grant_idx),
    .credit_overflow_o (credit_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_p = '0; m_grant = 0; m_count = CR; m_ptr = 0; m_ovf = 1'b0;
  endtask

  // Asserted at a negedge; outputs are checked before any clock edge occurs.
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; link_ready = 1'b0; credit_return = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(link_valid), 64'd0);
    check("rst_p", 64'(link_p), 64'd0);
    check("rst_count", 64'(credit_count), 64'(CR));
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_ovf", 64'(credit_overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs.
  task automatic cycle(input logic [3:0] rv, input logic lr, input logic cr);
    bit           load_en;
    int           win, nc, idx;
    logic [N-1:0] exp_ready;
    req_valid = rv; link_ready = lr; credit_return = cr;
    for (int i = 0; i < N; i++) req_p[i*PW +: PW] = $urandom;
    #1;
    load_en = (!m_valid || lr) && (m_count > 0);
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (win < 0 && rv[idx]) win = idx;
    end
    exp_ready = (load_en && win >= 0) ? (4'b0001 << win) : 4'b0000;
    obs_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    nc = m_count + int'(cr);
    if (load_en && win >= 0) begin
      m_p = req_p[win*PW +: PW]; m_valid = 1'b1; m_grant = win; m_ptr = (win + 1) % N;
      nc = nc - 1;
    end else if (lr && m_valid) begin
      m_valid = 1'b0;
    end
    if (nc > CR) m_ovf = 1'b1;
    else m_count = nc;
    @(negedge clk);
    check("link_valid", 64'(link_valid), 64'(m_valid));
    check("link_p", 64'(link_p), 64'(m_p));
    check("grant_idx", 64'(grant_idx), 64'(m_grant));
    check("credit_count", 64'(credit_count), 64'(m_count));
    check("credit_overflow", 64'(credit_overflow), 64'(m_ovf));
  endtask

  initial begin
    logic [PW-1:0] held_p;
    rst = 1'b1; req_valid = '0; req_p = '0; link_ready = 1'b0; credit_return = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Credits exhaust after exactly four beats, grants 0..3.
    vecs[0] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0, 3};
    vecs[1] = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1, 2};
    vecs[2] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2, 1};
    vecs[3] = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 3, 0};
    vecs[4] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 3, 0};
    vecs[5] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 3, 0};
    for (int v = 0; v < 6; v++) begin
      cycle(vecs[v].rv, vecs[v].lr, vecs[v].cr);
      check("tbl_ready", 64'(obs_ready), 64'(vecs[v].exp_ready));
      check("tbl_valid", 64'(link_valid), 64'(vecs[v].exp_valid));
      check("tbl_grant", 64'(grant_idx), 64'(vecs[v].exp_grant));
      check("tbl_count", 64'(credit_count), 64'(vecs[v].exp_count));
    end

    // A single returned credit buys exactly one beat, one cycle later.
    cycle(4'b1111, 1'b1, 1'b1);
    check("ret_ready_same", 64'(obs_ready), 64'd0);
    check("ret_count", 64'(credit_count), 64'd1);
    cycle(4'b1111, 1'b1, 1'b0);
    check("ret_ready_next", 64'(obs_ready), 64'b0001);
    check("ret_valid", 64'(link_valid), 64'd1);
    check("ret_count0", 64'(credit_count), 64'd0);
    cycle(4'b1111, 1'b1, 1'b0);
    check("ret_one_only", 64'(obs_ready), 64'd0);

    // Held beat stays stable under backpressure; credit spent only once.
    do_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    held_p = link_p;
    repeat (3) begin
      cycle(4'b0001, 1'b0, 1'b0);
      check("hold_ready", 64'(obs_ready), 64'd0);
      check("hold_p", 64'(link_p), 64'(held_p));
      check("hold_valid", 64'(link_valid), 64'd1);
      check("hold_count", 64'(credit_count), 64'd3);
    end
    cycle(4'b0001, 1'b1, 1'b0);
    check("hold_release_count", 64'(credit_count), 64'd2);

    // Load and return in the same cycle leave the count unchanged.
    do_reset();
    cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1);
    check("simul_count", 64'(credit_count), 64'd2);

    // Sparse requesters: idle slots skipped.
    do_reset();
    exp_g = '{0, 2, 0, 2};
    for (int j = 0; j < 4; j++) begin
      cycle(4'b0101, 1'b1, 1'b1);
      check("sparse_grant", 64'(grant_idx), 64'(exp_g[j]));
      check("sparse_count", 64'(credit_count), 64'(CR));
    end

    // Overflow saturates, is sticky, and is cleared only by reset.
    do_reset();
    cycle(4'b0000, 1'b1, 1'b1);
    check("ovf_count", 64'(credit_count), 64'(CR));
    check("ovf_set", 64'(credit_overflow), 64'd1);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);
    check("ovf_sticky", 64'(credit_overflow), 64'd1);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic against the model, with occasional resets.
    for (int r = 0; r < 3000; r++) begin
      if (r % 700 == 699) do_reset();
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
